// File: rtl/wir_pkg.sv
// Shared definitions for the WIR loader: default length, FSM states and
// the named instruction cell positions.
package wir_pkg;

    localparam int WIR_LEN_DEF = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Cell positions within the 12-bit instruction (bit 0 is nearest wir_si)
    localparam int WPC        = 0;
    localparam int WSC_SEL    = 1;
    localparam int WDR_SEL0   = 2;
    localparam int WDR_SEL1   = 3;
    localparam int WDR_SEL2   = 4;
    localparam int WDR_SEL3   = 5;
    localparam int WDR_SEL4   = 6;
    localparam int WDR_SEL5   = 7;
    localparam int WDR_SEL6   = 8;
    localparam int WDR_SEL7   = 9;
    localparam int WBY        = 10;
    localparam int WPP_BYPASS = 11;

endpackage

// File: rtl/wir_shift_ctr.sv
// Shift-cycle counter: counts 0..LEN-1 while enabled, flags the last cycle
// and returns to zero as the shift phase ends.
module wir_shift_ctr #(
    parameter int LEN = 12
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(LEN);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CW'(LEN - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wir_loader.sv
// Loads one instruction into a 1500-style WIR (capture, shift, update) and
// returns the value shifted out of wir_so as the response.
module wir_loader
    import wir_pkg::*;
#(
    parameter int WIR_LEN = WIR_LEN_DEF
) (
    input  logic               WRCK,
    input  logic               WRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIR_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIR_LEN-1:0] rsp_data,
    output logic               wir_capture,
    output logic               wir_shift,
    output logic               wir_update,
    output logic               select_wir,
    output logic               wir_si,
    input  logic               wir_so,
    output logic               busy
);

    state_e             state_q;
    logic [WIR_LEN-1:0] cmd_q;
    logic [WIR_LEN-1:0] rsp_q;
    logic               cmd_ready_q, rsp_valid_q, busy_q;
    logic               cap_q, shf_q, upd_q, sel_q, si_q;
    logic               last_shift;

    wir_shift_ctr #(.LEN(WIR_LEN)) u_ctr (
        .clk_i (WRCK),
        .rst_i (WRST),
        .en_i  (state_q == SHIFT),
        .tc_o  (last_shift)
    );

    // Every output is registered so each control is glitch-free on the WIR.
    always_ff @(posedge WRCK) begin
        if (WRST) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cap_q       <= 1'b0;
            shf_q       <= 1'b0;
            upd_q       <= 1'b0;
            sel_q       <= 1'b0;
            si_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q       <= cmd_data;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cap_q       <= 1'b1;
                        sel_q       <= 1'b1;
                        state_q     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    cap_q   <= 1'b0;
                    shf_q   <= 1'b1;
                    si_q    <= cmd_q[WIR_LEN-1];
                    cmd_q   <= cmd_q << 1;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    // MSB of the response is the first bit out of wir_so
                    rsp_q <= {rsp_q[WIR_LEN-2:0], wir_so};
                    if (last_shift) begin
                        shf_q   <= 1'b0;
                        upd_q   <= 1'b1;
                        si_q    <= 1'b0;
                        state_q <= UPDATE;
                    end else begin
                        si_q  <= cmd_q[WIR_LEN-1];
                        cmd_q <= cmd_q << 1;
                    end
                end
                UPDATE: begin
                    upd_q       <= 1'b0;
                    sel_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cap_q       <= 1'b0;
                    shf_q       <= 1'b0;
                    upd_q       <= 1'b0;
                    sel_q       <= 1'b0;
                    si_q        <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_q;
    assign wir_capture = cap_q;
    assign wir_shift   = shf_q;
    assign wir_update  = upd_q;
    assign select_wir  = sel_q;
    assign wir_si      = si_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_wir_loader.sv
// Bench for wir_loader: a behavioural WIR on the serial side, a scoreboard of
// expected responses/cell values, and a per-cycle control-signal monitor.
module tb_wir_loader;

    localparam int L = 12;

    logic         WRCK = 1'b0;
    logic         WRST;
    logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [L-1:0] cmd_data, rsp_data;
    logic         wir_capture, wir_shift, wir_update, select_wir, wir_si, wir_so, busy;

    wir_loader #(.WIR_LEN(L)) dut (
        .WRCK(WRCK), .WRST(WRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .wir_capture(wir_capture), .wir_shift(wir_shift), .wir_update(wir_update),
        .select_wir(select_wir), .wir_si(wir_si), .wir_so(wir_so), .busy(busy)
    );

    always #5 WRCK = ~WRCK;

    // Behavioural WIR: si enters cell 0, so leaves from cell L-1.
    logic [L-1:0] wir_sr  = '0;
    logic [L-1:0] wir_upd = '0;
    assign wir_so = wir_sr[L-1];
    always @(posedge WRCK) begin
        if (wir_capture)    wir_sr <= wir_upd;
        else if (wir_shift) wir_sr <= {wir_sr[L-2:0], wir_si};
        if (wir_update)     wir_upd <= wir_sr;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a command returns the cells left by the last completed
    // command and leaves its own value in the cells.
    logic [L-1:0] exp_rsp[$];
    logic [L-1:0] exp_cell[$];
    logic [L-1:0] ref_cells = '0;
    logic [L-1:0] prev_ref;

    int n_cap = 0, n_shf = 0, n_upd = 0;

    initial begin : monitor
        logic         pv, phs;
        logic [L-1:0] pd;
        pv = 0; phs = 0; pd = '0;
        forever begin
            @(negedge WRCK);
            if (WRST) begin
                n_cap = 0; n_shf = 0; n_upd = 0;
                pv = 0; phs = 0;
            end else begin
                n_cap += int'(wir_capture);
                n_shf += int'(wir_shift);
                n_upd += int'(wir_update);
                chk("ctrl_onehot", 32'($countones({wir_capture, wir_shift, wir_update}) <= 1), 1);
                chk("select_wir", select_wir, wir_capture | wir_shift | wir_update);
                chk("busy_vs_ready", busy, !cmd_ready);
                if (!wir_shift) chk("wir_si_idle", wir_si, 0);
                if (rsp_valid && pv && !phs) chk("rsp_stable", rsp_data, pd);
                if (rsp_valid) chk("cmd_ready_in_done", cmd_ready, 0);
                if (rsp_valid && rsp_ready) begin
                    if (exp_rsp.size() == 0) chk("sb_underflow", 1, 0);
                    else begin
                        chk("rsp_data", rsp_data, exp_rsp.pop_front());
                        chk("wir_cells", wir_upd, exp_cell.pop_front());
                    end
                    chk("n_capture", n_cap, 1);
                    chk("n_shift", n_shf, L);
                    chk("n_update", n_upd, 1);
                    n_cap = 0; n_shf = 0; n_upd = 0;
                end
                pv = rsp_valid; pd = rsp_data; phs = rsp_valid && rsp_ready;
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!cmd_ready && t < 50) begin
            @(posedge WRCK); #1; t++;
        end
        if (t >= 50) chk("ready_timeout", 0, 1);
    endtask

    task automatic accept(input logic [L-1:0] c);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(posedge WRCK);
        exp_rsp.push_back(ref_cells);
        exp_cell.push_back(c);
        prev_ref  = ref_cells;
        ref_cells = c;
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [L-1:0] c, input int dly, input bit inject);
        int  t;
        bit  got;
        accept(c);
        t = 0; got = 0;
        while (t < 100) begin
            cmd_data = L'($urandom);
            if (inject && t == 4) begin
                cmd_valid = 1'b1;
                cmd_data  = '1;
            end else if (inject && t == 6) cmd_valid = 1'b0;
            @(negedge WRCK);
            if (rsp_valid) begin got = 1; break; end
            @(posedge WRCK); #1; t++;
        end
        cmd_valid = 1'b0;
        // t counts edges after the accept edge; DONE follows the edge L+2 later
        chk("rsp_latency", got ? t : -1, L + 2);
        @(posedge WRCK); #1;
        repeat (dly) begin @(posedge WRCK); #1; end
        rsp_ready = 1'b1;
        @(posedge WRCK); #1;
        rsp_ready = 1'b0;
        chk("cmd_ready_after_hs", cmd_ready, 1);
    endtask

    task automatic reset_mid_shift(input logic [L-1:0] c);
        accept(c);
        repeat (6) begin @(posedge WRCK); #1; end
        chk("rst_in_shift", wir_shift, 1);
        chk("rst_pre_shifts", n_shf, 5);
        chk("rst_pre_update", n_upd, 0);
        WRST = 1'b1;
        @(posedge WRCK); #1;
        WRST = 1'b0;
        chk("rst_ctrls", {wir_capture, wir_shift, wir_update, select_wir, wir_si}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        void'(exp_rsp.pop_back());
        void'(exp_cell.pop_back());
        ref_cells = prev_ref;
        repeat (3) @(posedge WRCK); #1;
        chk("rst_no_update", wir_upd, prev_ref);
    endtask

    initial begin
        WRST = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_data = '0;
        repeat (3) @(posedge WRCK); #1;
        WRST = 1'b0;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_ctrls", {wir_capture, wir_shift, wir_update, select_wir, wir_si}, 0);
        chk("reset_busy", busy, 0);

        send(12'hA5C, 0, 0);
        chk("cells_A5C", wir_upd, 12'hA5C);
        send(12'h3F1, 0, 0);
        chk("cells_3F1", wir_upd, 12'h3F1);
        send(12'h5A3, 1, 1);
        chk("cells_after_inject", wir_upd, 12'h5A3);
        send(12'h0F0, 10, 0);
        reset_mid_shift(12'hC3C);
        send(12'h123, 0, 0);

        for (int i = 0; i < 20; i++)
            send(L'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

        repeat (5) @(posedge WRCK); #1;
        chk("sb_empty", exp_rsp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wir_loader.md
WIR_LOADER -- requirements
Module: wir_loader

Interface
REQ-001 Parameter WIR_LEN, default 12, SHALL set the instruction length in bits; it is legal from 2 to 32.
REQ-002 Port WRCK, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port WRST, input, 1, SHALL be the reset; it is synchronous and active-high.
REQ-004 Port cmd_valid, input, 1, SHALL indicate that cmd_data holds an instruction to load.
REQ-005 Port cmd_ready, output, 1, SHALL indicate the loader accepts a command this cycle.
REQ-006 Port cmd_data, input, WIR_LEN, SHALL carry the instruction; bit 0 = wir_wpc cell, bit WIR_LEN-1 = wir_wpp_bypass cell.
REQ-007 Port rsp_valid, output, 1, SHALL indicate that rsp_data holds the captured WIR contents.
REQ-008 Port rsp_ready, input, 1, SHALL indicate the consumer accepts the response.
REQ-009 Port rsp_data, output, WIR_LEN, SHALL carry the value shifted out of wir_so, in the same bit order as cmd_data.
REQ-010 Ports wir_capture, wir_shift and wir_update, output, 1 each, SHALL drive the same-named WIR controls.
REQ-011 Port select_wir, output, 1, SHALL select the WIR path.
REQ-012 Port wir_si, output, 1, SHALL be the serial data into the WIR.
REQ-013 Port wir_so, input, 1, SHALL be the serial data out of the WIR.
REQ-014 Port busy, output, 1, SHALL be high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, CAPTURE, SHIFT, UPDATE and DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-017 On acceptance, cmd_data SHALL be latched into a shift register and the FSM SHALL go IDLE->CAPTURE.
REQ-018 CAPTURE SHALL last 1 cycle with wir_capture=1, then go to SHIFT.
REQ-019 SHIFT SHALL last exactly WIR_LEN cycles with wir_shift=1, then go to UPDATE.
REQ-020 wir_si SHALL present bit WIR_LEN-1-k of the latched instruction in shift cycle k (k=0..WIR_LEN-1), MSB first, so bit i ends in cell i.
REQ-021 In shift cycle k, the loader SHALL sample wir_so at the closing WRCK edge into rsp_data[WIR_LEN-1-k].
REQ-022 UPDATE SHALL last 1 cycle with wir_update=1, then go to DONE.
REQ-023 select_wir SHALL be 1 in CAPTURE, SHIFT and UPDATE, and 0 otherwise.
REQ-024 wir_capture, wir_shift and wir_update SHALL be mutually exclusive; all three SHALL be 0 in IDLE and DONE.
REQ-025 In DONE, rsp_valid=1 and rsp_data SHALL stay stable until rsp_ready=1.
REQ-026 The rsp_valid&rsp_ready handshake SHALL return the FSM to IDLE; cmd_ready rises the following cycle.
REQ-027 Latency SHALL be: accept at edge N, rsp_valid high from cycle N+WIR_LEN+3.
REQ-028 The shift counter SHALL be ceil(log2(WIR_LEN)) bits wide, count 0..WIR_LEN-1 with no wrap beyond, and clear on SHIFT exit.
REQ-029 cmd_valid while busy SHALL be ignored without side effects; cmd_data changes while busy SHALL NOT affect the transfer in progress.
REQ-030 wir_si SHALL be 0 outside SHIFT.

Reset
REQ-031 WRST=1 at any edge SHALL force IDLE, including mid-SHIFT or during DONE; any response in progress is discarded.
REQ-032 Reset values SHALL be: cmd_ready=1 after reset release, rsp_valid=0, rsp_data=0, wir_capture=0, wir_shift=0, wir_update=0, select_wir=0, wir_si=0, busy=0, counter=0.

Structure
REQ-033 Package wir_pkg SHALL hold WIR_LEN default, the FSM state enum, and the named cell-bit index constants (WPC=0 ... WPP_BYPASS=11).
REQ-034 The shift counter with its terminal-count flag SHALL be one sub-module, wir_shift_ctr; all else is flat.

Verification
REQ-035 Bench SHALL cover: WIR model preloaded with 12'h000, cmd 12'hA5C -> after update WIR cells=12'hA5C, rsp_data = captured 12'h000, rsp_valid at cycle N+15.
REQ-036 Bench SHALL cover back-to-back commands 12'hA5C then 12'h3F1 -> second rsp_data=12'hA5C (or the model's capture value), and cell outputs=12'h3F1.
REQ-037 Bench SHALL cover cmd_valid pulsed during SHIFT with cmd_data=12'hFFF -> ignored; loaded value unchanged.
REQ-038 Bench SHALL cover rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout.
REQ-039 Bench SHALL cover WRST=1 at shift cycle 5 -> next cycle all controls 0, IDLE, busy=0; the WIR update was never issued.
REQ-040 Bench SHALL check the control signals every cycle -> exactly one capture, WIR_LEN shifts and one update per command; never two controls high together.
